// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RISC-V style control FSM with memory wait and trap handling
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 3,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  instr_done,
    output logic                  illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state;
    state_t     state_next;
    logic       rdy;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       done_raw;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl3;
    logic       unused_bits;

    // Only funct7[5] matters for the sub/add split; the rest of funct7 is don't-care here.
    assign unused_bits = ^{funct7[6], funct7[4:0]};

    // With waiting disabled every memory handshake completes immediately.
    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Sticky illegal-opcode flag, set on the edge that enters TRAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_op <= 1'b0;
        end else if (state_next == S_TRAP) begin
            illegal_op <= 1'b1;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        done_raw   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_FETCH: begin
                ir_write  = rdy;
                pc_update = rdy;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BEQ:            state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (rdy) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                reg_write  = 1'b1;
                done_raw   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held through the whole wait; retire only on the completing cycle.
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                done_raw  = rdy;
                if (rdy) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                done_raw   = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                done_raw   = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                done_raw   = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // ALU operation decode; funct7[5] only selects sub for register-register ops.
    always_comb begin
        alu_ctrl3 = 3'b000;
        case (alu_op)
            2'b01: alu_ctrl3 = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_ctrl3 = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctrl3 = 3'b101;
                    3'b110:  alu_ctrl3 = 3'b011;
                    3'b111:  alu_ctrl3 = 3'b010;
                    default: alu_ctrl3 = 3'b000;
                endcase
            end
            default: alu_ctrl3 = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    assign ALUControl = ALU_CTRL_W'(alu_ctrl3);

    // Write strobes and retire pulse are suppressed while reset is held.
    assign PCWrite    = rst & (pc_update | (branch & zero));
    assign IRWrite    = rst & ir_write;
    assign RegWrite   = rst & reg_write;
    assign MemWrite   = rst & mem_write;
    assign instr_done = rst & done_raw;

endmodule
